// File: rtl/comp_search_if.sv
// comp_search_if: search control, comparator and result signals of comp_search.
// master is the requester/comparator side; slave is comp_search itself.
interface comp_search_if;
   logic       start;
   logic [3:0] probe;
   logic       cmp_eq;
   logic       cmp_lt;
   logic       cmp_gt;
   logic       busy;
   logic       done;
   logic       found;
   logic       err;
   logic [3:0] result;
   logic [2:0] steps;

   modport master (
      output start, cmp_eq, cmp_lt, cmp_gt,
      input  probe, busy, done, found, err, result, steps
   );

   modport slave (
      input  start, cmp_eq, cmp_lt, cmp_gt,
      output probe, busy, done, found, err, result, steps
   );
endinterface

// File: rtl/comp_search.sv
// comp_search: binary search of a 4-bit target through an external comparator.
// Define COMP_SEARCH_STEPCNT_EN to count SAMPLE evaluations on steps; otherwise steps is 0.
module comp_search (
   input  logic          clk,
   input  logic          rst_n,
   comp_search_if.slave  bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DRIVE  = 2'd1;
   localparam logic [1:0] SAMPLE = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0] state_q, state_d;
   logic [3:0] lo_q, lo_d;
   logic [3:0] hi_q, hi_d;
   logic [3:0] probe_q, probe_d;
   logic [3:0] result_q, result_d;
   logic       found_q, found_d;
   logic       err_q, err_d;
   logic [4:0] sum_up, sum_dn;
   logic       one_hot;

   // Midpoints in 5 bits so probe+1+hi never wraps; the invariant lo<=probe keeps sum_dn non-negative.
   assign sum_up  = {1'b0, probe_q} + 5'd1 + {1'b0, hi_q};
   assign sum_dn  = {1'b0, lo_q} + {1'b0, probe_q} - 5'd1;
   assign one_hot = (bus.cmp_eq ^ bus.cmp_lt ^ bus.cmp_gt) & ~(bus.cmp_eq & bus.cmp_lt & bus.cmp_gt);

   always_comb begin
      state_d  = state_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      probe_d  = probe_q;
      result_d = result_q;
      found_d  = found_q;
      err_d    = err_q;
      case (state_q)
         IDLE: if (bus.start) begin
            lo_d    = 4'd0;
            hi_d    = 4'd15;
            probe_d = 4'd7;
            found_d = 1'b0;
            err_d   = 1'b0;
            state_d = DRIVE;
         end
         DRIVE: state_d = SAMPLE;
         SAMPLE: begin
            state_d = DONE;
            if (!one_hot) err_d = 1'b1;
            else if (bus.cmp_eq) begin
               result_d = probe_q;
               found_d  = 1'b1;
            end else if (bus.cmp_lt && probe_q != hi_q) begin
               lo_d    = probe_q + 4'd1;
               probe_d = sum_up[4:1];
               state_d = DRIVE;
            end else if (bus.cmp_gt && probe_q != lo_q) begin
               hi_d    = probe_q - 4'd1;
               probe_d = sum_dn[4:1];
               state_d = DRIVE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         lo_q     <= 4'd0;
         hi_q     <= 4'd15;
         probe_q  <= 4'd0;
         result_q <= 4'd0;
         found_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         probe_q  <= probe_d;
         result_q <= result_d;
         found_q  <= found_d;
         err_q    <= err_d;
      end
   end

`ifdef COMP_SEARCH_STEPCNT_EN
   logic [2:0] steps_q, steps_d;

   always_comb begin
      steps_d = steps_q;
      if (state_q == IDLE && bus.start) steps_d = 3'd0;
      else if (state_q == SAMPLE) steps_d = steps_q + 3'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) steps_q <= 3'd0;
      else steps_q <= steps_d;
   end

   assign bus.steps = steps_q;
`else
   assign bus.steps = 3'd0;
`endif

   assign bus.probe  = probe_q;
   assign bus.busy   = state_q == DRIVE || state_q == SAMPLE;
   assign bus.done   = state_q == DONE;
   assign bus.found  = found_q;
   assign bus.err    = err_q;
   assign bus.result = result_q;
endmodule

// File: tb/tb_comp_search.sv
// tb_comp_search: directed vector table plus busy-restart and mid-search reset sequences.
module tb_comp_search;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] target = 4'd0;
   logic [2:0] mode = 3'd0;
   int         checks = 0;
   int         errors = 0;

   comp_search_if bus();

   comp_search dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // mode 0 true compare, 1 gt only, 2 no flags, 3 lt and gt, 4 lt only
   always_comb begin
      bus.cmp_eq = mode == 3'd0 && bus.probe == target;
      bus.cmp_lt = (mode == 3'd0 && bus.probe < target) || mode == 3'd3 || mode == 3'd4;
      bus.cmp_gt = (mode == 3'd0 && bus.probe > target) || mode == 3'd1 || mode == 3'd3;
   end

   typedef struct {
      logic [3:0]  target;
      logic [2:0]  mode;
      bit          repulse;
      int          n;
      logic [19:0] probes;
      bit          found;
      bit          err;
      logic [3:0]  result;
   } vec_t;

   vec_t v[9];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run(input vec_t t, input int idx);
      int          cyc;
      int          pc;
      logic [19:0] got;
      logic [3:0]  last;
      int          exp_steps;
      cyc = 0;
      pc = 0;
      got = '0;
      last = '0;
`ifdef COMP_SEARCH_STEPCNT_EN
      exp_steps = t.n;
`else
      exp_steps = 0;
`endif
      target = t.target;
      mode = t.mode;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      while (!bus.done && cyc < 40) begin
         if (bus.busy && (pc == 0 || bus.probe != last)) begin
            if (pc < 5) got[4*pc +: 4] = bus.probe;
            last = bus.probe;
            pc++;
         end
         if (t.repulse) bus.start = cyc == 3;
         @(posedge clk);
         #1 cyc++;
      end
      bus.start = 1'b0;
      chk($sformatf("v%0d latency", idx), cyc, 2 * t.n);
      chk($sformatf("v%0d probe_count", idx), pc, t.n);
      chk($sformatf("v%0d probes", idx), int'(got), int'(t.probes));
      chk($sformatf("v%0d found", idx), int'(bus.found), int'(t.found));
      chk($sformatf("v%0d err", idx), int'(bus.err), int'(t.err));
      if (t.found) chk($sformatf("v%0d result", idx), int'(bus.result), int'(t.result));
      chk($sformatf("v%0d steps", idx), int'(bus.steps), exp_steps);
      @(posedge clk);
      #1 chk($sformatf("v%0d done_pulse", idx), int'(bus.done), 0);
      chk($sformatf("v%0d idle_busy", idx), int'(bus.busy), 0);
      mode = 3'd2;
      repeat (3) @(posedge clk);
      #1 chk($sformatf("v%0d hold_found", idx), int'(bus.found), int'(t.found));
      chk($sformatf("v%0d hold_err", idx), int'(bus.err), int'(t.err));
      if (t.found) chk($sformatf("v%0d hold_result", idx), int'(bus.result), int'(t.result));
   endtask

   initial begin
      bit seen_done;
      bus.start = 1'b0;
      v[0] = '{4'd7,  3'd0, 1'b0, 1, 20'h00007, 1'b1, 1'b0, 4'd7};
      v[1] = '{4'd15, 3'd0, 1'b0, 5, 20'hFEDB7, 1'b1, 1'b0, 4'd15};
      v[2] = '{4'd0,  3'd0, 1'b0, 4, 20'h00137, 1'b1, 1'b0, 4'd0};
      v[3] = '{4'd0,  3'd1, 1'b0, 4, 20'h00137, 1'b0, 1'b0, 4'd0};
      v[4] = '{4'd5,  3'd2, 1'b0, 1, 20'h00007, 1'b0, 1'b1, 4'd0};
      v[5] = '{4'd5,  3'd3, 1'b0, 1, 20'h00007, 1'b0, 1'b1, 4'd0};
      v[6] = '{4'd9,  3'd0, 1'b1, 3, 20'h009B7, 1'b1, 1'b0, 4'd9};
      v[7] = '{4'd4,  3'd0, 1'b0, 4, 20'h04537, 1'b1, 1'b0, 4'd4};
      v[8] = '{4'd0,  3'd4, 1'b0, 5, 20'hFEDB7, 1'b0, 1'b0, 4'd0};
      repeat (3) @(posedge clk);
      #1 chk("rst probe", int'(bus.probe), 0);
      chk("rst busy", int'(bus.busy), 0);
      chk("rst done", int'(bus.done), 0);
      chk("rst found", int'(bus.found), 0);
      chk("rst err", int'(bus.err), 0);
      chk("rst result", int'(bus.result), 0);
      chk("rst steps", int'(bus.steps), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) run(v[i], i);
      // Abort a target-15 search in its third DRIVE cycle.
      target = 4'd15;
      mode = 3'd0;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1 chk("abort in_drive busy", int'(bus.busy), 1);
      chk("abort in_drive probe", int'(bus.probe), 13);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("abort probe", int'(bus.probe), 0);
      chk("abort busy", int'(bus.busy), 0);
      chk("abort done", int'(bus.done), 0);
      chk("abort found", int'(bus.found), 0);
      chk("abort err", int'(bus.err), 0);
      chk("abort result", int'(bus.result), 0);
      chk("abort steps", int'(bus.steps), 0);
      seen_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1 seen_done |= bus.done | bus.busy;
      end
      chk("abort no_done", int'(seen_done), 0);
      run(v[1], 9);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/comp_search.md
COMP_SEARCH -- requirements
Module: comp_search

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset. Ports are clk and rst_n, and all state SHALL update only on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 probe  output  4  value driven to the external comparator's a port (the comparator's b port carries the target).
REQ-006 cmp_eq, cmp_lt, cmp_gt  input  1 each  comparator flags: probe==target, probe<target, probe>target.
REQ-007 busy  output  1  high in DRIVE and SAMPLE.
REQ-008 done  output  1  one-cycle pulse when a search ends.
REQ-009 found  output  1  target located; valid from done until the next start.
REQ-010 err  output  1  illegal flag combination seen; valid from done until the next start.
REQ-011 result  output  4  located value; valid when found=1.
REQ-012 steps  output  3  number of SAMPLE evaluations in the last search (see Configuration).

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, SAMPLE and DONE. Internal registers SHALL be lo[3:0], hi[3:0] and probe[3:0].
REQ-014 In IDLE with start=1 at edge k, the block SHALL set lo<=0, hi<=15, probe<=7 and state<=DRIVE, and SHALL clear found, err and steps.
REQ-015 DRIVE SHALL last exactly one cycle (comparator settle) and then go to SAMPLE. probe SHALL be held stable through DRIVE and SAMPLE.
REQ-016 In SAMPLE, exactly one flag high is legal. Flags are evaluated in SAMPLE only; flag values in other states SHALL be ignored.
REQ-017 SAMPLE with cmp_eq: result<=probe, found<=1, state<=DONE.
REQ-018 SAMPLE with cmp_lt and probe!=hi: lo<=probe+1, probe<=floor((probe+1+hi)/2), state<=DRIVE.
REQ-019 SAMPLE with cmp_gt and probe!=lo: hi<=probe-1, probe<=floor((lo+probe-1)/2), state<=DRIVE.
REQ-020 Midpoint sums SHALL use 5-bit arithmetic, with no 4-bit wrap.
REQ-021 SAMPLE with cmp_lt and probe==hi, or cmp_gt and probe==lo (range exhausted): found<=0, err<=0, state<=DONE. lo and hi SHALL never wrap.
REQ-022 SAMPLE with zero flags or more than one flag high: err<=1, found<=0, state<=DONE.
REQ-023 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-024 found, err and result SHALL hold until the next accepted start.
REQ-025 start asserted outside IDLE SHALL be ignored. It is not queued.
REQ-026 Latency: each probe step SHALL take 2 cycles. done SHALL be high in the cycle after edge k+2n, where n is the number of SAMPLE evaluations (n<=5).

Reset
REQ-027 While rst_n=0 at a rising edge, the block SHALL set state<=IDLE; probe, lo, result, steps <=0; hi<=15; busy, done, found, err <=0.
REQ-028 Reset asserted mid-search SHALL abort the search without a done pulse. The first cycle after release SHALL be IDLE.

Configuration
REQ-029 Macro COMP_SEARCH_STEPCNT_EN defined: steps SHALL increment by 1 on every SAMPLE evaluation and hold its final value until the next start.
REQ-030 Macro COMP_SEARCH_STEPCNT_EN undefined: steps SHALL be constant 0 and no counter logic is present. All other behaviour SHALL be identical.

Verification
REQ-031 Target 7, start at edge 0 -> probe 7, done in cycle after edge 2, found=1, result=7, steps=1.
REQ-032 Target 15 -> probes 7, 11, 13, 14, 15; done after edge 10; result=15; steps=5.
REQ-033 Target 0 -> probes 7, 3, 1, 0; result=0; steps=4. Flags forced cmp_gt always -> probes 7, 3, 1, 0, then done with found=0, err=0.
REQ-034 Flags all 0 in the first SAMPLE -> done after edge 2, err=1, found=0. Flags cmp_lt=cmp_gt=1 -> same response.
REQ-035 Re-pulse start while busy -> ignored, search completes normally. rst_n=0 during the third DRIVE -> no done pulse, all outputs at reset values, next start searches correctly.
REQ-036 Build without COMP_SEARCH_STEPCNT_EN and run REQ-032 -> identical probes and result, steps=0.
